// File: rtl/tdc_readout_pkg.sv
// +----------------------------------------------------------------------+
// | tdc_readout_pkg                                                       |
// | Shared state encoding and default constants for the TDC readout seq.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package tdc_readout_pkg;

  localparam int c_num_ch_dflt      = 4;
  localparam int c_load_cycles_dflt = 32;
  localparam int c_timeout_cyc_dflt = 1024;
  localparam int c_load_cnt_w       = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ACQUIRE = 3'd2,
    S_LOAD    = 3'd3,
    S_WAIT    = 3'd4,
    S_DRAIN   = 3'd5,
    S_DONE    = 3'd6
  } tdc_state_t;

endpackage

`default_nettype wire

// File: rtl/tdc_rr_arb.sv
// +----------------------------------------------------------------------+
// | tdc_rr_arb                                                            |
// | Round-robin search for the next non-empty channel above ch_sel.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tdc_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] empty,
  input  logic [CH_W-1:0]   ch_sel,
  output logic [CH_W-1:0]   next_ch,
  output logic              any_valid
);

  logic            w_found_hi;
  logic [CH_W-1:0] w_hi;
  logic [CH_W-1:0] w_lo;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    w_found_hi = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        w_lo = CH_W'(i);
        if (i > int'(ch_sel)) begin
          w_hi       = CH_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
  end

  assign next_ch   = w_found_hi ? w_hi : w_lo;
  assign any_valid = ~&empty;

endmodule

`default_nettype wire

// File: rtl/tdc_readout_seq.sv
// +----------------------------------------------------------------------+
// | tdc_readout_seq                                                       |
// | Clear/acquire/load/drain sequencer for multi-channel TDC FIFOs.       |
// | Optional WAIT watchdog: define TDC_READOUT_TIMEOUT_EN.                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tdc_readout_seq
  import tdc_readout_pkg::*;
#(
  parameter int  NUM_CH      = c_num_ch_dflt,
  parameter int  LOAD_CYCLES = c_load_cycles_dflt,
  parameter int  TIMEOUT_CYC = c_timeout_cyc_dflt,
  localparam int c_ch_w      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              max,
  input  logic [NUM_CH-1:0] empty,
  output logic              clr,
  output logic              ce,
  output logic              ld,
  output logic [NUM_CH-1:0] rden,
  output logic [c_ch_w-1:0] ch_sel,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam logic [c_load_cnt_w-1:0] c_load_last = c_load_cnt_w'(LOAD_CYCLES - 1);
  localparam logic [c_ch_w-1:0]       c_last_ch   = c_ch_w'(NUM_CH - 1);

  tdc_state_t              r_state;
  tdc_state_t              w_next_state;
  logic [c_load_cnt_w-1:0] r_load_cnt;
  logic [c_ch_w-1:0]       r_ch_sel;
  logic [c_ch_w-1:0]       w_arb_base;
  logic [c_ch_w-1:0]       w_arb_next;
  logic                    w_any_valid;
  logic [NUM_CH-1:0]       w_sel_onehot;

  // From WAIT, searching above the top channel yields the lowest non-empty one.
  assign w_arb_base   = (r_state == S_WAIT) ? c_last_ch : r_ch_sel;
  assign w_sel_onehot = NUM_CH'(1) << r_ch_sel;

  tdc_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (c_ch_w)
  ) u_rr_arb (
    .empty     (empty),
    .ch_sel    (w_arb_base),
    .next_ch   (w_arb_next),
    .any_valid (w_any_valid)
  );

`ifdef TDC_READOUT_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_tmo_w-1:0] r_wait_cnt;
  logic               r_timeout_err;
  logic               w_wait_expired;

  assign w_wait_expired = (r_wait_cnt == c_tmo_w'(TIMEOUT_CYC - 1)) && !w_any_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (r_state == S_WAIT && w_next_state == S_DONE)
        r_timeout_err <= 1'b1;
      else if (w_next_state != S_DONE)
        r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // Constant 0; the comparison only consumes TIMEOUT_CYC in this build.
  assign timeout_err = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Dropping start aborts every active state before any other condition.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_CLEAR;
      S_CLEAR:   w_next_state = start ? S_ACQUIRE : S_IDLE;
      S_ACQUIRE: begin
        if (!start)  w_next_state = S_IDLE;
        else if (max) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (!start)                        w_next_state = S_IDLE;
        else if (r_load_cnt == c_load_last) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (!start)           w_next_state = S_IDLE;
        else if (w_any_valid) w_next_state = S_DRAIN;
`ifdef TDC_READOUT_TIMEOUT_EN
        else if (w_wait_expired) w_next_state = S_DONE;
`endif
      end
      S_DRAIN: begin
        if (!start)                               w_next_state = S_IDLE;
        else if (empty[r_ch_sel] && !w_any_valid) w_next_state = S_DONE;
      end
      S_DONE:    if (!start) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_cnt <= '0;
      r_ch_sel   <= '0;
    end else begin
      r_load_cnt <= (r_state == S_LOAD) ? r_load_cnt + 1'b1 : '0;
      if (w_next_state == S_IDLE)
        r_ch_sel <= '0;
      else if (w_next_state == S_DRAIN && (r_state == S_WAIT || empty[r_ch_sel]))
        r_ch_sel <= w_arb_next;
    end
  end

  always_comb begin
    clr  = 1'b0;
    ce   = 1'b0;
    ld   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    rden = '0;
    case (r_state)
      S_IDLE:    clr = 1'b1;
      S_CLEAR:   begin clr = 1'b1; busy = 1'b1; end
      S_ACQUIRE: begin ce  = 1'b1; busy = 1'b1; end
      S_LOAD:    begin ld  = 1'b1; busy = 1'b1; end
      S_WAIT:    busy = 1'b1;
      S_DRAIN: begin
        busy = 1'b1;
        if (start) rden = w_sel_onehot & ~empty;
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  assign ch_sel = r_ch_sel;

endmodule

`default_nettype wire

// File: tb/tb_tdc_readout_seq.sv
// +----------------------------------------------------------------------+
// | tb_tdc_readout_seq                                                    |
// | Directed and randomized checks of tdc_readout_seq against a model.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tdc_readout_seq;

  localparam int N  = 4;
  localparam int LC = 32;
  localparam int TO = 16;

  localparam int P_IDLE = 0, P_CLR = 1, P_ACQ = 2, P_LOAD = 3, P_WAIT = 4, P_DRAIN = 5, P_DONE = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         max = 1'b0;
  logic [N-1:0] empty;
  logic         clr, ce, ld, busy, done, timeout_err;
  logic [N-1:0] rden;
  logic [1:0]   ch_sel;

  int fifo_cnt[N] = '{default: 0};
  int add_req[N]  = '{default: 0};
  int rd_log[$];
  int rd_total = 0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_ph = P_IDLE;
  int m_ldleft = 0;
  int m_wcnt = 0;
  int m_ch = 0;
  bit m_terr = 1'b0;

  tdc_readout_seq #(
    .NUM_CH      (N),
    .LOAD_CYCLES (LC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .max         (max),
    .empty       (empty),
    .clr         (clr),
    .ce          (ce),
    .ld          (ld),
    .rden        (rden),
    .ch_sel      (ch_sel),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    empty = '0;
    for (int i = 0; i < N; i++) empty[i] = (fifo_cnt[i] == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (fifo_cnt[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  // First channel holding data, scanning upward from s with wrap.
  function automatic int first_from(input int s);
    for (int k = 0; k < N; k++) if (fifo_cnt[(s + k) % N] > 0) return (s + k) % N;
    return 0;
  endfunction

  // FIFO environment: words are pushed by the stimulus and popped by rden.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      fifo_cnt[i] <= fifo_cnt[i] - ((rden[i] && fifo_cnt[i] > 0) ? 1 : 0) + add_req[i];
      if (rden[i]) begin
        rd_log.push_back(i);
        rd_total <= rd_total + 1;
      end
    end
  end

  // Reference sequence: phase plus remaining-load and wait-cycle counts.
  always @(posedge clk) begin
    if (reset) begin
      m_ph   <= P_IDLE;
      m_terr <= 1'b0;
      m_ch   <= 0;
    end else begin
      case (m_ph)
        P_IDLE: if (start) m_ph <= P_CLR;
        P_CLR:  m_ph <= start ? P_ACQ : P_IDLE;
        P_ACQ: begin
          if (!start) m_ph <= P_IDLE;
          else if (max) begin m_ph <= P_LOAD; m_ldleft <= LC; end
        end
        P_LOAD: begin
          if (!start) m_ph <= P_IDLE;
          else if (m_ldleft == 1) begin m_ph <= P_WAIT; m_wcnt <= 0; end
          else m_ldleft <= m_ldleft - 1;
        end
        P_WAIT: begin
          if (!start) m_ph <= P_IDLE;
          else if (!all_empty()) begin m_ph <= P_DRAIN; m_ch <= first_from(0); end
          else begin
            m_wcnt <= m_wcnt + 1;
`ifdef TDC_READOUT_TIMEOUT_EN
            if (m_wcnt + 1 == TO) begin m_ph <= P_DONE; m_terr <= 1'b1; end
`endif
          end
        end
        P_DRAIN: begin
          if (!start) m_ph <= P_IDLE;
          else if (fifo_cnt[m_ch] == 0) begin
            if (all_empty()) m_ph <= P_DONE;
            else m_ch <= first_from(m_ch + 1);
          end
        end
        P_DONE: if (!start) begin m_ph <= P_IDLE; m_terr <= 1'b0; end
        default: m_ph <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] exp_rden;
      exp_rden = (m_ph == P_DRAIN && start && fifo_cnt[m_ch] > 0) ? (32'd1 << m_ch) : 32'd0;
      chk("m_clr",  clr,  (m_ph == P_IDLE || m_ph == P_CLR));
      chk("m_ce",   ce,   (m_ph == P_ACQ));
      chk("m_ld",   ld,   (m_ph == P_LOAD));
      chk("m_busy", busy, !(m_ph == P_IDLE || m_ph == P_DONE));
      chk("m_done", done, (m_ph == P_DONE));
      chk("m_terr", timeout_err, m_terr);
      chk("m_rden", rden, exp_rden);
      if (m_ph == P_DRAIN) chk("m_ch_sel", ch_sel, m_ch);
      for (int i = 0; i < N; i++)
        if (rden[i] && fifo_cnt[i] == 0) chk("rd_of_empty", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b, input int c, input int d);
    add_req[0] = a; add_req[1] = b; add_req[2] = c; add_req[3] = d;
    tick();
    for (int i = 0; i < N; i++) add_req[i] = 0;
  endtask

  // Advance to the negedge of the first cycle after ld falls; returns ld-high count.
  task automatic wait_load_end(output int ldn);
    ldn = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ld) ldn++;
      else if (ldn > 0) break;
    end
  endtask

  initial begin
    int ldn;
    int w;
    bit done_seen;
    int exp_seq[6];
    exp_seq = '{0, 0, 0, 2, 2, 3};

    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_clr", clr, 1);
    chk("rst_ce", ce, 0);
    chk("rst_ld", ld, 0);
    chk("rst_rden", rden, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    tick();
    reset = 1'b0;

    // Preloaded 3/0/2/1 words, max arrives on the 10th cycle of the run.
    push(3, 0, 2, 1);
    rd_log.delete();
    start = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    max = 1'b1;
    tick();
    max = 1'b0;
    wait_load_end(ldn);
    chk("ld_cycles", ldn, 32);
    chk("wait_ld", ld, 0);
    chk("wait_busy", busy, 1);
    chk("wait_rden", rden, 0);
    for (int c = 0; c < 100; c++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("drain_done", done, 1);
    chk("rd_total", rd_total, 6);
    chk("rd_count", rd_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < rd_log.size()) chk("rd_order", rd_log[i], exp_seq[i]);
    tick();
    start = 1'b0;
    tick();

    // Abort during the 5th LOAD cycle.
    start = 1'b1;
    max   = 1'b1;
    ldn   = 0;
    for (int c = 0; c < 50 && ldn < 4; c++) begin
      @(negedge clk);
      if (ld) ldn++;
    end
    tick();
    start = 1'b0;
    max   = 1'b0;
    @(negedge clk);
    chk("abort_ld5", ld, 1);
    @(negedge clk);
    chk("abort_ld", ld, 0);
    chk("abort_clr", clr, 1);
    chk("abort_busy", busy, 0);
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);

    // All FIFOs empty in WAIT.
    tick();
    start = 1'b1;
    max   = 1'b1;
    wait_load_end(ldn);
    max = 1'b0;
`ifdef TDC_READOUT_TIMEOUT_EN
    w = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) break;
      w++;
    end
    chk("tmo_cycles", w, 16);
    chk("tmo_done", done, 1);
    chk("tmo_err", timeout_err, 1);
`else
    w = 0;
    for (int c = 0; c < 100; c++) @(negedge clk);
    chk("nowd_busy", busy, 1);
    chk("nowd_done", done, 0);
    chk("nowd_ld", ld, 0);
    chk("nowd_terr", timeout_err, 0);
`endif
    tick();
    start = 1'b0;
    tick();
    tick();

    // Reset while draining channel 2.
    push(0, 0, 5, 0);
    start = 1'b1;
    max   = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rden != 0) break;
    end
    chk("mid_rden2", rden, 4'b0100);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ch_sel", ch_sel, 2);
    @(negedge clk);
    chk("rst2_rden", rden, 0);
    chk("rst2_ch_sel", ch_sel, 0);
    chk("rst2_clr", clr, 1);
    chk("rst2_busy", busy, 0);
    tick();
    reset = 1'b0;
    start = 1'b0;
    max   = 1'b0;

    // Randomized traffic: refills, max pulses, aborts and sporadic resets.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!start) start = ($urandom_range(0, 3) == 0);
      else        start = ($urandom_range(0, 59) != 0);
      max = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < N; i++)
        add_req[i] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
      tick();
    end
    for (int i = 0; i < N; i++) add_req[i] = 0;
    start = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
